change_dispenser: RTL

- Coin-output side of the vending subsystem. Accepts a change-due request in 5-unit steps and issues coins one at a time on a valid/ack coin interface. Coin codes are 2'b01 for a 5 coin and 2'b10 for a 10 coin.
- Tracks hopper inventory per denomination and reports any amount it cannot pay.
- Sits between the vending controller and the coin hopper driver.

---
 rtl/change_dispenser.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount (in 5-units) as a sequence of
// 10 and 5 coins on a valid/ack coin interface. It tracks hopper inventory
// for each denomination and reports any part of a request it could not pay.
//
// Handshakes:
//   Request side: a request is taken on a rising edge where req_valid and
//   req_ready are both high. req_ready is high only in IDLE.
//   Coin side: coin_out is held stable while coin_valid is high. The coin
//   is consumed on a rising edge where coin_valid and coin_ack are both high.
//   coin_ack has no effect while coin_valid is low.
//
// Every output comes from a flop or is decoded from the state register, so
// there is no combinational path from any input to any output.
// state_dbg mirrors the state register: 0 IDLE, 1 SELECT, 2 ISSUE, 3 DONE.
module change_dispenser #(
  parameter int AMT_W    = 4,
  parameter int CNT_W    = 8,
  parameter int INIT_ONE = 20,
  parameter int INIT_TWO = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [CNT_W-1:0] refill_one,
  input  logic [CNT_W-1:0] refill_two,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] shortfall,
  output logic [CNT_W-1:0] inv_one,
  output logic [CNT_W-1:0] inv_two,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] COIN_IDLE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic             short_q, short_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic [CNT_W-1:0] inv_one_q, inv_one_d;
  logic [CNT_W-1:0] inv_two_q, inv_two_d;

  // Inventory add that clamps at the counter's all-ones value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // State and datapath registers; reset abandons any coin in flight and
  // reloads the hopper counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      coin_q      <= COIN_IDLE;
      short_q     <= 1'b0;
      shortfall_q <= '0;
      inv_one_q   <= CNT_W'(INIT_ONE);
      inv_two_q   <= CNT_W'(INIT_TWO);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      short_q     <= short_d;
      shortfall_q <= shortfall_d;
      inv_one_q   <= inv_one_d;
      inv_two_q   <= inv_two_d;
    end
  end

  // Next-state logic: greedy coin choice, payout bookkeeping and refill.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    short_d     = short_q;
    shortfall_d = shortfall_q;
    inv_one_d   = inv_one_q;
    inv_two_d   = inv_two_q;
    case (state_q)
      S_IDLE: begin
        // A request wins over a refill arriving on the same edge.
        if (req_valid) begin
          remaining_d = req_amount;
          short_d     = 1'b0;
          shortfall_d = '0;
          state_d     = S_SELECT;
        end else if (refill) begin
          inv_one_d = sat_add(inv_one_q, refill_one);
          inv_two_d = sat_add(inv_two_q, refill_two);
        end
      end
      S_SELECT: begin
        // A coin is only picked when its count is non-zero, so the
        // inventory can never wrap below zero.
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (remaining_q >= AMT_W'(2) && inv_two_q != '0) begin
          coin_d  = COIN_TEN;
          state_d = S_ISSUE;
        end else if (inv_one_q != '0) begin
          coin_d  = COIN_FIVE;
          state_d = S_ISSUE;
        end else begin
          short_d     = 1'b1;
          shortfall_d = remaining_q;
          state_d     = S_DONE;
        end
      end
      S_ISSUE: begin
        if (coin_ack) begin
          if (coin_q == COIN_TEN) begin
            remaining_d = remaining_q - AMT_W'(2);
            inv_two_d   = inv_two_q - CNT_W'(1);
          end else begin
            remaining_d = remaining_q - AMT_W'(1);
            inv_one_d   = inv_one_q - CNT_W'(1);
          end
          coin_d  = COIN_IDLE;
          state_d = S_SELECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign coin_valid = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign coin_out   = coin_q;
  assign short      = short_q;
  assign shortfall  = shortfall_q;
  assign inv_one    = inv_one_q;
  assign inv_two    = inv_two_q;
  assign state_dbg  = state_q;

endmodule
